controlador_juego: RTL and testbench
====================================

# controlador_juego

Turn scheduler and board-state controller for the 3×3 game shown on the VGA output. It debounces the three player pushbuttons and moves a shared cursor. It alternates the single board resource between player 1 and player 2, detects win/draw, and publishes the board to the video generator. Display copies change only at frame start, so the picture never tears mid-frame. It sits between the board pushbuttons and the video generator, clocked from the 25 MHz pixel clock.

## Interface
- DEBOUNCE_CYCLES, 250000, consecutive stable cycles required to accept a button level (10 ms at 25 MHz).
- clk  in  1  25 MHz pixel clock (clk_25 domain); sole clock.
- rst_n  in  1  synchronous, active-low reset.
- boton_mover  in  1  raw pushbutton, active-low; advances cursor.
- boton_colocar  in  1  raw pushbutton, active-low; places current player's mark at cursor.
- boton_reiniciar  in  1  raw pushbutton, active-low; restarts game.
- v_sync  in  1  active-low vertical sync from the VGA controller; its falling edge is frame start.
- cursor  out  4  displayed cursor cell, 0..8 (row-major).
- celda_ocupada  out  9  displayed occupancy, bit i = cell i.
- celda_jugador  out  9  displayed owner, bit i: 0 = player 1, 1 = player 2; 0 when unoccupied.
- turno  out  1  player to move: 0 = player 1, 1 = player 2.
- gano  out  2  result: 0 none, 1 player 1, 2 player 2, 3 draw.

## Operation
- Each button uses its own debouncer:
  - 2-flop synchronizer followed by a counter.
  - Any sample equal to the accepted level clears the counter.
  - When the counter reaches DEBOUNCE_CYCLES, the accepted level updates.
  - A one-cycle press pulse fires on an accepted released→pressed transition only.
  - Reset sets the accepted level to released, so no pulse fires.
- Working board: shadow registers ocup_w[8:0] and jug_w[8:0]; cursor_w.
- FSM states:
  - JUGANDO:
    - Press mover → cursor_w = (cursor_w == 8) ? 0 : cursor_w + 1.
    - Press colocar on a free cell → write the cell with owner = turno, go to EVALUAR.
    - Press colocar on an occupied cell → ignored, no state change.
  - EVALUAR (exactly 1 cycle): test the 8 lines for the player who just moved.
    - Line complete → gano = turno+1, go to FIN.
    - Else all 9 cells occupied → gano = 3, go to FIN.
    - Else toggle turno, return to JUGANDO.
  - FIN: mover and colocar are ignored; the board is frozen.
- Press reiniciar, from any state: clears ocup_w/jug_w, cursor_w = 0, turno = 0, gano = 0, go to JUGANDO.
- Same-cycle priority: reiniciar > colocar > mover.
  - When colocar and mover pulse together, colocar uses the pre-move cursor and mover is dropped.
- Frame-start strobe = v_sync registered 1→0 transition. On the strobe, cursor/celda_ocupada/celda_jugador load from the shadow registers.
- turno and gano are direct registers, not frame-latched.

## Timing
- Reset values, applied at the first clk edge with rst_n = 0: all outputs 0, FSM = JUGANDO, debounce counters 0, v_sync history = 1.
- Press pulse is asserted DEBOUNCE_CYCLES+2 cycles after the first edge sampling the new raw level.
- Shadow write occurs on the edge after the pulse. gano/turno update on the following edge, at the end of EVALUAR.
- Displayed board updates on the edge after the next v_sync falling edge is registered: 2 cycles after v_sync falls.
- A move committed during the same cycle as the strobe appears at the next frame.
- rst_n asserted mid-EVALUAR aborts the evaluation; no gano update occurs.
- Reiniciar outputs: turno/gano clear 1 cycle after the pulse. Displayed board clears at the next frame start.
- Bounce shorter than DEBOUNCE_CYCLES produces no pulse.

## Structure
- Package juego_pkg:
  - estado_t enum {JUGANDO, EVALUAR, FIN}.
  - gano codes GANO_NADIE/GANO_J1/GANO_J2/GANO_EMPATE.
  - LINEAS constant: 8 index triples {0,1,2},{3,4,5},{6,7,8},{0,3,6},{1,4,7},{2,5,8},{0,4,8},{2,4,6}.
- Sub-module antirrebote (parameter DEBOUNCE_CYCLES, ports clk, rst_n, boton, pulso), instanced 3 times.
- Top-level vga instantiates controlador_juego and feeds its outputs to videoGenerador.

## Test plan
All scenarios use DEBOUNCE_CYCLES = 4.
- Reset, no buttons, 3 v_sync falls → all outputs 0, no pulses.
- Bounce: hold mover low 3 cycles, then high → no cursor change.
- Cursor wrap: 9 clean mover presses, then a v_sync fall → cursor reads 1..8, 0. Display changes only 2 cycles after each v_sync fall.
- Placements at cursor 0, 3, 1, 4, 2 → turno alternates. After the 5th placement gano = 1. The displayed board after the frame shows ocupada = 0x01F, jugador = 0x018. Further colocar is ignored.
- Colocar on an occupied cell → ocup/jug and turno unchanged.
- Draw sequence 0, 1, 2, 4, 3, 5, 7, 6, 8 → gano = 3 after the last EVALUAR.
- Reiniciar and colocar pulse in the same cycle → board cleared, no mark placed, turno = 0.

Source files
------------

// File: rtl/controlador_juego_pkg.sv
// juego_pkg: shared types for the 3x3 game controller.
// FSM states, result codes, the 8 winning lines and a line-check helper.
package juego_pkg;

  typedef enum logic [1:0] {
    JUGANDO,
    EVALUAR,
    FIN
  } estado_t;

  typedef enum logic [1:0] {
    GANO_NADIE  = 2'd0,
    GANO_J1     = 2'd1,
    GANO_J2     = 2'd2,
    GANO_EMPATE = 2'd3
  } gano_t;

  localparam logic [3:0] LINEAS [8][3] = '{
    '{4'd0, 4'd1, 4'd2},
    '{4'd3, 4'd4, 4'd5},
    '{4'd6, 4'd7, 4'd8},
    '{4'd0, 4'd3, 4'd6},
    '{4'd1, 4'd4, 4'd7},
    '{4'd2, 4'd5, 4'd8},
    '{4'd0, 4'd4, 4'd8},
    '{4'd2, 4'd4, 4'd6}
  };

  // m holds the cells owned by one player
  function automatic logic hay_linea(input logic [8:0] m);
    logic r;
    r = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (m[LINEAS[i][0]] && m[LINEAS[i][1]] &&
          m[LINEAS[i][2]])
        r = 1'b1;
    end
    return r;
  endfunction

endpackage

// File: rtl/controlador_juego_if.sv
// juego_if: buttons + v_sync into the controller, display board out.
// master = board/VGA side driving inputs, slave = controlador_juego.
interface juego_if;
  import juego_pkg::*;

  logic       boton_mover;
  logic       boton_colocar;
  logic       boton_reiniciar;
  logic       v_sync;
  logic [3:0] cursor;
  logic [8:0] celda_ocupada;
  logic [8:0] celda_jugador;
  logic       turno;
  logic [1:0] gano;

  modport master (
    output boton_mover, boton_colocar, boton_reiniciar,
    output v_sync,
    input  cursor, celda_ocupada, celda_jugador,
    input  turno, gano
  );

  modport slave (
    input  boton_mover, boton_colocar, boton_reiniciar,
    input  v_sync,
    output cursor, celda_ocupada, celda_jugador,
    output turno, gano
  );

endinterface

// File: rtl/controlador_juego_antirrebote.sv
// antirrebote: 2-flop sync + stability counter for an active-low button.
// Ports: clk, rst_n (sync, active-low), boton (raw), pulso (1-cycle press).
module antirrebote #(
  parameter int DEBOUNCE_CYCLES = 250000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic boton,
  output logic pulso
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

  logic          s1_q, s2_q;
  logic          acc_q;
  logic [CW-1:0] cnt_q;
  logic          pulso_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_q    <= 1'b1;
      s2_q    <= 1'b1;
      acc_q   <= 1'b1;
      cnt_q   <= '0;
      pulso_q <= 1'b0;
    end else begin
      s1_q    <= boton;
      s2_q    <= s1_q;
      pulso_q <= 1'b0;
      if (s2_q == acc_q) begin
        cnt_q <= '0;
      end else if (cnt_q == CW'(DEBOUNCE_CYCLES)) begin
        // level held long enough: accept it
        acc_q   <= s2_q;
        cnt_q   <= '0;
        pulso_q <= ~s2_q;
      end else begin
        cnt_q <= cnt_q + CW'(1);
      end
    end
  end

  assign pulso = pulso_q;

endmodule

// File: rtl/controlador_juego.sv
// controlador_juego: turn scheduler + board state, frame-latched display.
// Ports: clk, rst_n (sync, active-low), jif (juego_if.slave).
module controlador_juego
  import juego_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 250000
) (
  input  logic    clk,
  input  logic    rst_n,
  juego_if.slave  jif
);

  logic p_mov, p_col, p_rei;

  antirrebote #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_mov (
    .clk  (clk),
    .rst_n(rst_n),
    .boton(jif.boton_mover),
    .pulso(p_mov)
  );

  antirrebote #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_col (
    .clk  (clk),
    .rst_n(rst_n),
    .boton(jif.boton_colocar),
    .pulso(p_col)
  );

  antirrebote #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_rei (
    .clk  (clk),
    .rst_n(rst_n),
    .boton(jif.boton_reiniciar),
    .pulso(p_rei)
  );

  estado_t    estado_q, estado_d;
  logic [8:0] ocup_q, ocup_d;
  logic [8:0] jug_q, jug_d;
  logic [3:0] cur_q, cur_d;
  logic       turno_q, turno_d;
  gano_t      gano_q, gano_d;

  logic       vs1_q, vs2_q;
  logic       frame_ini;
  logic [3:0] dcur_q;
  logic [8:0] docup_q, djug_q;
  logic [8:0] propias;

  assign frame_ini = vs2_q & ~vs1_q;
  assign propias   = ocup_q & (turno_q ? jug_q : ~jug_q);

  always_comb begin
    estado_d = estado_q;
    ocup_d   = ocup_q;
    jug_d    = jug_q;
    cur_d    = cur_q;
    turno_d  = turno_q;
    gano_d   = gano_q;
    if (p_rei) begin
      ocup_d   = '0;
      jug_d    = '0;
      cur_d    = '0;
      turno_d  = 1'b0;
      gano_d   = GANO_NADIE;
      estado_d = JUGANDO;
    end else begin
      unique case (estado_q)
        JUGANDO: begin
          // colocar wins over mover and uses the pre-move cursor
          if (p_col) begin
            if (!ocup_q[cur_q]) begin
              ocup_d[cur_q] = 1'b1;
              jug_d[cur_q]  = turno_q;
              estado_d      = EVALUAR;
            end
          end else if (p_mov) begin
            cur_d = (cur_q == 4'd8) ? 4'd0 : cur_q + 4'd1;
          end
        end
        EVALUAR: begin
          if (hay_linea(propias)) begin
            gano_d   = turno_q ? GANO_J2 : GANO_J1;
            estado_d = FIN;
          end else if (&ocup_q) begin
            gano_d   = GANO_EMPATE;
            estado_d = FIN;
          end else begin
            turno_d  = ~turno_q;
            estado_d = JUGANDO;
          end
        end
        FIN: begin
          estado_d = FIN;
        end
        default: estado_d = JUGANDO;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      estado_q <= JUGANDO;
      ocup_q   <= '0;
      jug_q    <= '0;
      cur_q    <= '0;
      turno_q  <= 1'b0;
      gano_q   <= GANO_NADIE;
      vs1_q    <= 1'b1;
      vs2_q    <= 1'b1;
      dcur_q   <= '0;
      docup_q  <= '0;
      djug_q   <= '0;
    end else begin
      estado_q <= estado_d;
      ocup_q   <= ocup_d;
      jug_q    <= jug_d;
      cur_q    <= cur_d;
      turno_q  <= turno_d;
      gano_q   <= gano_d;
      vs1_q    <= jif.v_sync;
      vs2_q    <= vs1_q;
      // a same-edge shadow write lands in the next frame
      if (frame_ini) begin
        dcur_q  <= cur_q;
        docup_q <= ocup_q;
        djug_q  <= jug_q;
      end
    end
  end

  assign jif.cursor        = dcur_q;
  assign jif.celda_ocupada = docup_q;
  assign jif.celda_jugador = djug_q;
  assign jif.turno         = turno_q;
  assign jif.gano          = gano_q;

endmodule

// File: tb/tb_controlador_juego.sv
// tb_controlador_juego: directed vectors, DEBOUNCE_CYCLES = 4.
// Drives juego_if as master, checks display/turno/gano.
module tb_controlador_juego;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_cmp = 0;
  int   n_err = 0;

  logic [3:0] cur;
  logic [3:0] dc;
  logic [8:0] dov, djv;

  juego_if jif ();

  controlador_juego #(.DEBOUNCE_CYCLES(4)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .jif  (jif)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  task automatic rel();
    jif.boton_mover     = 1'b1;
    jif.boton_colocar   = 1'b1;
    jif.boton_reiniciar = 1'b1;
  endtask

  // 0 mover, 1 colocar, 2 reiniciar, 3 reiniciar+colocar
  task automatic press(input int b);
    @(negedge clk);
    case (b)
      0: jif.boton_mover = 1'b0;
      1: jif.boton_colocar = 1'b0;
      2: jif.boton_reiniciar = 1'b0;
      default: begin
        jif.boton_reiniciar = 1'b0;
        jif.boton_colocar   = 1'b0;
      end
    endcase
    repeat (12) @(negedge clk);
    rel();
    repeat (12) @(negedge clk);
  endtask

  task automatic goto(input logic [3:0] c);
    while (cur != c) begin
      press(0);
      cur = (cur == 4'd8) ? 4'd0 : cur + 4'd1;
    end
  endtask

  task automatic frame(input logic [3:0] c,
                       input logic [8:0] o,
                       input logic [8:0] j);
    jif.v_sync = 1'b0;
    @(negedge clk);
    chk("cur_early", jif.cursor, dc);
    chk("ocup_early", jif.celda_ocupada, dov);
    chk("jug_early", jif.celda_jugador, djv);
    @(negedge clk);
    chk("cur", jif.cursor, c);
    chk("ocup", jif.celda_ocupada, o);
    chk("jug", jif.celda_jugador, j);
    dc  = c;
    dov = o;
    djv = j;
    jif.v_sync = 1'b1;
    repeat (3) @(negedge clk);
  endtask

  task automatic place(input logic [3:0] c,
                       input logic t,
                       input logic [1:0] g);
    goto(c);
    press(1);
    chk("turno", jif.turno, t);
    chk("gano", jif.gano, g);
  endtask

  int draw_seq [9] = '{0, 1, 2, 4, 3, 5, 7, 6, 8};

  initial begin
    rel();
    jif.v_sync = 1'b1;
    cur = 4'd0;
    dc  = 4'd0;
    dov = 9'd0;
    djv = 9'd0;

    // reset
    repeat (3) @(negedge clk);
    chk("rst_cur", jif.cursor, 4'd0);
    chk("rst_ocup", jif.celda_ocupada, 9'd0);
    chk("rst_jug", jif.celda_jugador, 9'd0);
    chk("rst_turno", jif.turno, 1'b0);
    chk("rst_gano", jif.gano, 2'd0);
    rst_n = 1'b1;
    repeat (3) frame(4'd0, 9'd0, 9'd0);

    // bounce shorter than the debounce window
    @(negedge clk);
    jif.boton_mover = 1'b0;
    repeat (3) @(negedge clk);
    jif.boton_mover = 1'b1;
    repeat (12) @(negedge clk);
    frame(4'd0, 9'd0, 9'd0);

    // cursor wrap 1..8, 0
    for (int i = 0; i < 9; i++) begin
      press(0);
      cur = (cur == 4'd8) ? 4'd0 : cur + 4'd1;
      frame(cur, 9'd0, 9'd0);
    end

    // first placement at cell 0, exact turno timing
    @(negedge clk);
    jif.boton_colocar = 1'b0;
    repeat (8) @(negedge clk);
    chk("turno_pre", jif.turno, 1'b0);
    @(negedge clk);
    chk("turno_post", jif.turno, 1'b1);
    repeat (4) @(negedge clk);
    rel();
    repeat (12) @(negedge clk);

    // P1 wins on the top row
    place(4'd3, 1'b0, 2'd0);
    place(4'd1, 1'b1, 2'd0);
    place(4'd4, 1'b0, 2'd0);
    place(4'd2, 1'b0, 2'd1);
    frame(4'd2, 9'h01F, 9'h018);

    // board frozen in FIN
    press(1);
    press(0);
    chk("fin_gano", jif.gano, 2'd1);
    chk("fin_turno", jif.turno, 1'b0);
    frame(4'd2, 9'h01F, 9'h018);

    // restart: regs clear now, display at next frame
    press(2);
    cur = 4'd0;
    chk("rei_turno", jif.turno, 1'b0);
    chk("rei_gano", jif.gano, 2'd0);
    chk("rei_disp_held", jif.celda_ocupada, 9'h01F);
    frame(4'd0, 9'd0, 9'd0);

    // colocar on an occupied cell
    place(4'd0, 1'b1, 2'd0);
    press(1);
    chk("occ_turno", jif.turno, 1'b1);
    chk("occ_gano", jif.gano, 2'd0);
    frame(4'd0, 9'h001, 9'h000);

    // draw
    press(2);
    cur = 4'd0;
    for (int i = 0; i < 9; i++) begin
      if (i < 8)
        place(4'(draw_seq[i]), (i % 2 == 0), 2'd0);
      else
        place(4'(draw_seq[i]), 1'b0, 2'd3);
    end
    frame(4'd8, 9'h1FF, 9'h072);

    // reiniciar and colocar in the same cycle
    press(2);
    cur = 4'd0;
    place(4'd0, 1'b1, 2'd0);
    goto(4'd1);
    press(3);
    cur = 4'd0;
    chk("both_turno", jif.turno, 1'b0);
    chk("both_gano", jif.gano, 2'd0);
    frame(4'd0, 9'd0, 9'd0);

    // reset while in EVALUAR
    @(negedge clk);
    jif.boton_colocar = 1'b0;
    repeat (8) @(negedge clk);
    rst_n = 1'b0;
    rel();
    @(negedge clk);
    rst_n = 1'b1;
    chk("abort_turno", jif.turno, 1'b0);
    chk("abort_gano", jif.gano, 2'd0);
    repeat (12) @(negedge clk);
    chk("abort_turno2", jif.turno, 1'b0);
    frame(4'd0, 9'd0, 9'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got running want finished");
    $fatal(1, "timeout");
  end

endmodule
